sbox_share_ctrl: RTL and testbench
==================================

// Module: sbox_share_ctrl
// PURPOSE
//  Time-multiplexes one small bank of NUM_SBOX SBox instances between two requesters:
//  the round datapath (128-bit SubBytes, 16 bytes) and the key schedule (32-bit SubWord, 4 bytes).
//  Replaces the 16-SBox parallel SubBytes stage in area-reduced AES builds.
//  Arbitrates, sequences the byte slices through the bank and returns registered results with done pulses.
// PARAMETERS
//  NUM_SBOX  4  SBox instances in the bank; legal values 4, 8, 16; BEATS = 16/NUM_SBOX
// PORTS
//  clk           in   1    rising-edge clock
//  rst_n         in   1    synchronous reset, active low
//  st_valid      in   1    round datapath requests SubBytes on st_data_in
//  st_ready      out  1    st_valid accepted this cycle
//  st_data_in    in   128  state; byte i = [8i+7:8i]
//  st_data_out   out  128  SubBytes(st_data_in) of last completed state job
//  st_done       out  1    one-cycle pulse: st_data_out just updated
//  key_valid     in   1    key schedule requests SubWord on key_data_in
//  key_ready     out  1    key_valid accepted this cycle
//  key_data_in   in   32   word; byte i = [8i+7:8i]
//  key_data_out  out  32   SubWord(key_data_in) of last completed key job
//  key_done      out  1    one-cycle pulse: key_data_out just updated
//  busy          out  1    FSM not in IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): FSM=IDLE, beat=0, last_grant=KEY, all outputs and data regs 0.
//    Reset mid-job aborts it: no done pulse, results stay 0.
//  - FSM states: IDLE, ST_RUN, ST_DONE, KEY_RUN, KEY_DONE.
//  - Readies are combinational, asserted only in IDLE, and never both high:
//    st_ready  = IDLE & st_valid & (!key_valid | last_grant==KEY)
//    key_ready = IDLE & key_valid & (!st_valid | last_grant==ST)
//  - Tie-break is round-robin. A lone requester always wins. last_grant updates on every accept.
//  - Requesters hold valid/data until their ready. Input data is captured into an internal
//    working register on accept and need not be held afterwards.
//  - ST accept (cycle T): go to ST_RUN, beat=0.
//    ST_RUN: each cycle, bytes [beat*NUM_SBOX +: NUM_SBOX] pass through the bank into the working result.
//    beat increments each cycle. At beat==BEATS-1, go to ST_DONE (beat wraps to 0).
//    ST_DONE: st_data_out <= full result, st_done=1 for this cycle only, then IDLE.
//    st_done high in cycle T+BEATS+1 (T+5 at default). Next accept possible at T+BEATS+2.
//  - KEY accept (cycle T): go to KEY_RUN. Bank lanes 0..3 take key bytes 0..3; any lanes 4+ are unused.
//    Then KEY_DONE: key_data_out updates, key_done=1, then IDLE. key_done high at T+2.
//  - Outputs hold their last result until that requester's next done. The other requester's job never disturbs them.
//  - st_done and key_done are never high in the same cycle.
//  - Valid asserted while busy: ignored until IDLE; no request is lost while valid is held.
//  - SBox is the existing combinational AES S-box (data_in[7:0] -> data_out[7:0]).
//    The bank output is registered into the working result each beat, so there is no comb path from inputs to outputs.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clks -> every output 0, busy=0, st_ready=key_ready=0.
//  2 st_data_in=0x0F0E..0100, lone request -> st_done 5 clks after accept (NUM_SBOX=4);
//    st_data_out=0x76abd7fe2b670130c56f6bf27b777c63.
//  3 key_data_in=0x093c4fcf (bytes cf,4f,3c,09), lone request -> key_done 2 clks after accept;
//    key_data_out=0x01eb848a.
//  4 st_valid and key_valid both high from reset -> ST granted first (last_grant=KEY), KEY next.
//    Both high again after KEY finishes -> ST granted, confirming alternation.
//    key_data_out is unchanged during ST jobs.
//  5 rst_n=0 in ST_RUN beat 2 -> no st_done; st_data_out=0; FSM=IDLE.
//    A fresh request after reset completes normally.
//  6 Sweep NUM_SBOX in {4,8,16} with all-0x53 state -> st_data_out all 0xED;
//    st_done latency BEATS+1 = 5/3/2.

Source files
------------

// File: rtl/sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// sbox_share_ctrl
//   Time-multiplexes a bank of NUM_SBOX AES S-boxes between the round datapath
//   (128-bit SubBytes) and the key schedule (32-bit SubWord). A state job streams
//   NUM_SBOX bytes per cycle through the bank over BEATS = 16/NUM_SBOX cycles. A
//   key job uses lanes 0..3 for one cycle. The two requesters are served by
//   round-robin arbitration, and each gets registered results with a done pulse.
//
// Parameters
//   NUM_SBOX      S-box lanes in the bank; legal values are 4, 8 and 16
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous reset, active low
//   st_valid      round datapath requests SubBytes on st_data_in
//   st_ready      st_valid accepted this cycle (combinational, IDLE only)
//   st_data_in    128-bit state, byte i = [8i+7:8i]
//   st_data_out   SubBytes result of the last completed state job
//   st_done       one-cycle pulse: st_data_out has just been updated
//   key_valid     key schedule requests SubWord on key_data_in
//   key_ready     key_valid accepted this cycle (combinational, IDLE only)
//   key_data_in   32-bit word, byte i = [8i+7:8i]
//   key_data_out  SubWord result of the last completed key job
//   key_done      one-cycle pulse: key_data_out has just been updated
//   busy          controller is not idle
// -----------------------------------------------------------------------------
module sbox_share_ctrl #(
  parameter int NUM_SBOX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           st_valid,
  output logic           st_ready,
  input  logic [127:0]   st_data_in,
  output logic [127:0]   st_data_out,
  output logic           st_done,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [31:0]    key_data_in,
  output logic [31:0]    key_data_out,
  output logic           key_done,
  output logic           busy
);

  localparam int BEATS   = 16 / NUM_SBOX;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W = NUM_SBOX * 8;

  localparam logic GRANT_ST  = 1'b0;
  localparam logic GRANT_KEY = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ST_RUN   = 3'd1,
    ST_DONE  = 3'd2,
    KEY_RUN  = 3'd3,
    KEY_DONE = 3'd4
  } state_t;

  // GF(2^8) multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    logic [7:0] r;
    if (a[7]) begin
      r = {a[6:0], 1'b0} ^ 8'h1b;
    end else begin
      r = {a[6:0], 1'b0};
    end
    return r;
  endfunction

  // GF(2^8) multiply by shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (as a^254, which maps 0 to 0) then the affine map
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [BEAT_W-1:0]   beat_r;
  logic                last_grant_r;
  logic [127:0]        work_in_r;
  logic [127:0]        work_res_r;
  logic [127:0]        st_out_r;
  logic [31:0]         key_out_r;

  logic                last_beat_s;
  logic [6:0]          slice_base_s;
  logic [SLICE_W-1:0]  bank_in_s;
  logic [SLICE_W-1:0]  bank_out_s;
  logic [127:0]        res_merged_s;

  assign last_beat_s  = (beat_r == BEAT_W'(BEATS - 1));
  // Highest base is 128-SLICE_W, which always fits in 7 bits.
  assign slice_base_s = 7'(beat_r) * 7'(SLICE_W);

  // The shared S-box bank, one lane per byte
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    assign bank_out_s[8*g +: 8] = sbox_byte(bank_in_s[8*g +: 8]);
  end

  // Bank input mux: the current state slice, or the key word on lanes 0..3
  always_comb begin
    bank_in_s = '0;
    case (state_r)
      ST_RUN:  bank_in_s       = work_in_r[slice_base_s +: SLICE_W];
      KEY_RUN: bank_in_s[31:0] = work_in_r[31:0];
      default: bank_in_s       = '0;
    endcase
  end

  // Merge the bank output into the working result at the active slice
  always_comb begin
    res_merged_s = work_res_r;
    if (state_r == ST_RUN) begin
      res_merged_s[slice_base_s +: SLICE_W] = bank_out_s;
    end else if (state_r == KEY_RUN) begin
      res_merged_s[31:0] = bank_out_s[31:0];
    end else begin
      res_merged_s = work_res_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (st_ready) begin
          state_nxt_s = ST_RUN;
        end else if (key_ready) begin
          state_nxt_s = KEY_RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ST_RUN: begin
        if (last_beat_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE:  state_nxt_s = IDLE;
      KEY_RUN:  state_nxt_s = KEY_DONE;
      KEY_DONE: state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: round-robin readies in IDLE and state-decoded status pulses
  always_comb begin
    st_ready  = (state_r == IDLE) && st_valid  && (!key_valid || (last_grant_r == GRANT_KEY));
    key_ready = (state_r == IDLE) && key_valid && (!st_valid  || (last_grant_r == GRANT_ST));
    busy      = (state_r != IDLE);
    st_done   = (state_r == ST_DONE);
    key_done  = (state_r == KEY_DONE);
  end

  // Datapath: input capture, grant history, beat counter and result registers.
  // Results are published on the final bank edge so that they are already
  // visible in the cycle that carries the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_r       <= '0;
      last_grant_r <= GRANT_KEY;
      work_in_r    <= 128'd0;
      work_res_r   <= 128'd0;
      st_out_r     <= 128'd0;
      key_out_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (st_ready) begin
            work_in_r    <= st_data_in;
            work_res_r   <= 128'd0;
            last_grant_r <= GRANT_ST;
            beat_r       <= '0;
          end else if (key_ready) begin
            work_in_r    <= {96'd0, key_data_in};
            work_res_r   <= 128'd0;
            last_grant_r <= GRANT_KEY;
          end else begin
            work_in_r    <= work_in_r;
          end
        end
        ST_RUN: begin
          work_res_r <= res_merged_s;
          if (last_beat_s) begin
            beat_r   <= '0;
            st_out_r <= res_merged_s;
          end else begin
            beat_r   <= beat_r + BEAT_W'(1);
          end
        end
        KEY_RUN: begin
          work_res_r <= res_merged_s;
          key_out_r  <= res_merged_s[31:0];
        end
        default: begin
          beat_r <= beat_r;
        end
      endcase
    end
  end

  assign st_data_out  = st_out_r;
  assign key_data_out = key_out_r;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sbox_share_ctrl
//   Directed bench for sbox_share_ctrl. Three instances (NUM_SBOX = 4, 8, 16)
//   share the stimulus. The 4-lane instance is the main subject, and all three
//   are compared in the bank-width sweep after a common reset.
// -----------------------------------------------------------------------------
module tb_sbox_share_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_valid;
  logic [127:0] st_data_in;
  logic         key_valid;
  logic [31:0]  key_data_in;

  logic         st_ready_4, st_done_4, key_ready_4, key_done_4, busy_4;
  logic [127:0] st_data_out_4;
  logic [31:0]  key_data_out_4;
  logic         st_ready_8, st_done_8, key_ready_8, key_done_8, busy_8;
  logic [127:0] st_data_out_8;
  logic [31:0]  key_data_out_8;
  logic         st_ready_16, st_done_16, key_ready_16, key_done_16, busy_16;
  logic [127:0] st_data_out_16;
  logic [31:0]  key_data_out_16;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ST_IN_SEQ  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ST_EXP_SEQ = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] ST_IN_ZERO = 128'h0;
  localparam logic [127:0] ST_EXP_63  = {16{8'h63}};
  localparam logic [127:0] ST_IN_53   = {16{8'h53}};
  localparam logic [127:0] ST_EXP_ED  = {16{8'hed}};

  always #5 clk = ~clk;

  sbox_share_ctrl #(.NUM_SBOX(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready_4), .st_data_in(st_data_in),
    .st_data_out(st_data_out_4), .st_done(st_done_4),
    .key_valid(key_valid), .key_ready(key_ready_4), .key_data_in(key_data_in),
    .key_data_out(key_data_out_4), .key_done(key_done_4), .busy(busy_4)
  );

  sbox_share_ctrl #(.NUM_SBOX(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready_8), .st_data_in(st_data_in),
    .st_data_out(st_data_out_8), .st_done(st_done_8),
    .key_valid(key_valid), .key_ready(key_ready_8), .key_data_in(key_data_in),
    .key_data_out(key_data_out_8), .key_done(key_done_8), .busy(busy_8)
  );

  sbox_share_ctrl #(.NUM_SBOX(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready_16), .st_data_in(st_data_in),
    .st_data_out(st_data_out_16), .st_done(st_done_16),
    .key_valid(key_valid), .key_ready(key_ready_16), .key_data_in(key_data_in),
    .key_data_out(key_data_out_16), .key_done(key_done_16), .busy(busy_16)
  );

  // Cycles from the accept negedge to the st_done negedge, or -1 on timeout
  task automatic wait_st_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (st_done_4 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Cycles from the accept negedge to the key_done negedge, or -1 on timeout
  task automatic wait_key_done(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (key_done_4 === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; st_valid = 1'b0; key_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; key_valid = 1'b0;
    st_data_in = 128'd0; key_data_in = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({st_done_4, key_done_4, busy_4, st_ready_4, key_ready_4} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {st_done_4, key_done_4, busy_4, st_ready_4, key_ready_4});
    end
    checks++;
    if (st_data_out_4 !== 128'd0) begin
      errors++; $display("FAIL reset_st_out got %h want 0", st_data_out_4);
    end
    checks++;
    if (key_data_out_4 !== 32'd0) begin
      errors++; $display("FAIL reset_key_out got %h want 0", key_data_out_4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_st_single();
    int lat;
    @(posedge clk); #1;
    st_data_in = ST_IN_SEQ; st_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready_4 !== 1'b1 || key_ready_4 !== 1'b0) begin
      errors++; $display("FAIL st_single_ready got %b%b want 10", st_ready_4, key_ready_4);
    end
    @(posedge clk); #1;
    st_valid = 1'b0; st_data_in = {128{1'b1}};
    wait_st_done(20, lat);
    checks++;
    if (lat != 5) begin
      errors++; $display("FAIL st_single_latency got %0d want 5", lat);
    end
    checks++;
    if (st_data_out_4 !== ST_EXP_SEQ) begin
      errors++; $display("FAIL st_single_data got %h want %h", st_data_out_4, ST_EXP_SEQ);
    end
    @(negedge clk);
    checks++;
    if (st_done_4 !== 1'b0 || busy_4 !== 1'b0) begin
      errors++; $display("FAIL st_single_after got done=%b busy=%b want 0 0", st_done_4, busy_4);
    end
  endtask

  task automatic test_key_single();
    int lat;
    @(posedge clk); #1;
    key_data_in = 32'h093c4fcf; key_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready_4 !== 1'b1 || st_ready_4 !== 1'b0) begin
      errors++; $display("FAIL key_single_ready got %b%b want 10", key_ready_4, st_ready_4);
    end
    @(posedge clk); #1;
    key_valid = 1'b0; key_data_in = 32'hffffffff;
    wait_key_done(20, lat);
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL key_single_latency got %0d want 2", lat);
    end
    checks++;
    if (key_data_out_4 !== 32'h01eb848a) begin
      errors++; $display("FAIL key_single_data got %h want 01eb848a", key_data_out_4);
    end
    checks++;
    if (st_data_out_4 !== ST_EXP_SEQ) begin
      errors++; $display("FAIL key_single_st_kept got %h want %h", st_data_out_4, ST_EXP_SEQ);
    end
  endtask

  task automatic test_arbitration();
    int lat;
    bit disturbed;
    bit both_done;
    pulse_reset();
    st_data_in = ST_IN_ZERO; st_valid = 1'b1;
    key_data_in = 32'h00010203; key_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready_4 !== 1'b1 || key_ready_4 !== 1'b0) begin
      errors++; $display("FAIL arb_first got st=%b key=%b want 1 0", st_ready_4, key_ready_4);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    disturbed = 1'b0; both_done = 1'b0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (key_data_out_4 !== 32'd0 || key_done_4 !== 1'b0) disturbed = 1'b1;
      if (st_done_4 === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 5 || disturbed) begin
      errors++; $display("FAIL arb_st_job got lat=%0d disturbed=%0d want 5 0", lat, disturbed);
    end
    checks++;
    if (st_data_out_4 !== ST_EXP_63) begin
      errors++; $display("FAIL arb_st_data got %h want %h", st_data_out_4, ST_EXP_63);
    end
    @(negedge clk);
    checks++;
    if (key_ready_4 !== 1'b1 || st_ready_4 !== 1'b0) begin
      errors++; $display("FAIL arb_key_next got key=%b st=%b want 1 0", key_ready_4, st_ready_4);
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (st_done_4 === 1'b1 && key_done_4 === 1'b1) both_done = 1'b1;
      if (key_done_4 === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 2 || both_done) begin
      errors++; $display("FAIL arb_key_job got lat=%0d both=%0d want 2 0", lat, both_done);
    end
    checks++;
    if (key_data_out_4 !== 32'h637c777b || st_data_out_4 !== ST_EXP_63) begin
      errors++; $display("FAIL arb_key_data got %h / %h want 637c777b / %h",
                         key_data_out_4, st_data_out_4, ST_EXP_63);
    end
    @(posedge clk); #1;
    st_data_in = ST_IN_SEQ; st_valid = 1'b1;
    key_data_in = 32'h093c4fcf; key_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready_4 !== 1'b1 || key_ready_4 !== 1'b0) begin
      errors++; $display("FAIL arb_alternate got st=%b key=%b want 1 0", st_ready_4, key_ready_4);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    wait_st_done(20, lat);
    checks++;
    if (lat != 5 || key_data_out_4 !== 32'h637c777b || st_data_out_4 !== ST_EXP_SEQ) begin
      errors++; $display("FAIL arb_second_st got lat=%0d key=%h st=%h want 5 637c777b %h",
                         lat, key_data_out_4, st_data_out_4, ST_EXP_SEQ);
    end
    @(negedge clk);
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_key_done(20, lat);
    checks++;
    if (lat != 2 || key_data_out_4 !== 32'h01eb848a) begin
      errors++; $display("FAIL arb_second_key got lat=%0d data=%h want 2 01eb848a",
                         lat, key_data_out_4);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen_done;
    @(posedge clk); #1;
    st_data_in = ST_IN_ZERO; st_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready_4 !== 1'b1) begin
      errors++; $display("FAIL abort_accept got %b want 1", st_ready_4);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_4 !== 1'b1) begin
      errors++; $display("FAIL abort_busy got %b want 1", busy_4);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (st_done_4 !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || st_data_out_4 !== 128'd0 || busy_4 !== 1'b0) begin
      errors++; $display("FAIL abort_state got done=%0d data=%h busy=%b want 0 0 0",
                         seen_done, st_data_out_4, busy_4);
    end
    @(posedge clk); #1;
    st_data_in = ST_IN_SEQ; st_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    st_valid = 1'b0;
    wait_st_done(20, lat);
    checks++;
    if (lat != 5 || st_data_out_4 !== ST_EXP_SEQ) begin
      errors++; $display("FAIL abort_fresh got lat=%0d data=%h want 5 %h",
                         lat, st_data_out_4, ST_EXP_SEQ);
    end
  endtask

  task automatic test_sweep();
    int lat4, lat8, lat16;
    pulse_reset();
    st_data_in = ST_IN_53; st_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({st_ready_4, st_ready_8, st_ready_16} !== 3'b111) begin
      errors++; $display("FAIL sweep_ready got %b want 111", {st_ready_4, st_ready_8, st_ready_16});
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    lat4 = -1; lat8 = -1; lat16 = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (st_done_4 === 1'b1 && lat4 < 0) lat4 = i;
      if (st_done_8 === 1'b1 && lat8 < 0) lat8 = i;
      if (st_done_16 === 1'b1 && lat16 < 0) lat16 = i;
    end
    checks++;
    if (lat4 != 5 || lat8 != 3 || lat16 != 2) begin
      errors++; $display("FAIL sweep_latency got %0d/%0d/%0d want 5/3/2", lat4, lat8, lat16);
    end
    checks++;
    if (st_data_out_4 !== ST_EXP_ED || st_data_out_8 !== ST_EXP_ED || st_data_out_16 !== ST_EXP_ED) begin
      errors++; $display("FAIL sweep_data got %h %h %h want all ed",
                         st_data_out_4, st_data_out_8, st_data_out_16);
    end
  endtask

  initial begin
    test_reset();
    test_st_single();
    test_key_single();
    test_arbitration();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
